mmio_uart_ctrl: RTL and testbench
=================================

MMIO_UART_CTRL -- requirements
Module: mmio_uart_ctrl

Interface
- REQ-001: Parameter BASE, default 16'h0003, is the region tag compared against address[31:16].
- REQ-002: Parameter TXF_DEPTH, default 4, is the TX FIFO depth; it SHALL be a power of two, at least 2.
- REQ-003: Parameter BAUD_RESET, default 16'd433, is the reset value of the BAUD register.
- REQ-004: Ports SHALL be, in order:
  - clk  in  1  clock
  - n_reset  in  1  synchronous, active-low reset
  - address  in  32  CPU byte address
  - wdata  in  32  CPU write data
  - rdata  out  32  read data to CPU
  - memory_read  in  1  read request, level
  - memory_write  in  1  write request, level
  - tx_start  out  1  one-cycle transmit strobe to the UART
  - tx_data_in  out  8  transmit byte
  - tx_busy  in  1  UART transmitter busy
  - rx_valid  in  1  one-cycle received-byte strobe
  - rx_data  in  8  received byte
  - baud_tick_max  out  16  BAUD register value
  - irq  out  1  interrupt request
- REQ-005: clk is the clock; n_reset is a synchronous, active-low reset.

Function
- REQ-006: hit SHALL be asserted when address[31:16]==BASE; the register offset is address[15:0].
- REQ-007: Access side effects SHALL occur only on the first cycle of an access:
  - rd_stb = memory_read & hit & ~rd_q
  - wr_stb = memory_write & hit & ~wr_q
  - rd_q and wr_q register memory_read and memory_write every cycle.
- REQ-008: rdata SHALL be combinational and valid whenever memory_read & hit; it SHALL be 0 otherwise, and 0 at unmapped offsets.
- REQ-009: Offset 0x00 TXDATA:
  - wr_stb pushes wdata[7:0] into the TX FIFO.
  - Reads return 0.
- REQ-010: Offset 0x04 RXDATA:
  - Reads return {24'b0, rx_hold}.
  - rd_stb clears rx_full.
- REQ-011: Offset 0x08 STATUS reads back the following bits, all other bits 0:
  - [0] tx_full
  - [1] tx_empty
  - [2] rx_full
  - [3] rx_overrun
  - [4] tx_busy
  - [5] tx_overflow
- REQ-012: A STATUS write SHALL be write-1-to-clear for bits [3] and [5] only.
- REQ-013: Offset 0x0C BAUD SHALL be read/write on bits [15:0], and baud_tick_max SHALL equal the BAUD register.
- REQ-014: TX FIFO push-and-pop behaviour:
  - push_ok = wr_stb(TXDATA) & (count<TXF_DEPTH | pop).
  - A push that is refused is dropped and sets tx_overflow.
  - A push and a pop in the same cycle leave count unchanged.
  - The pointers wrap modulo TXF_DEPTH.
- REQ-015: The transmit FSM SHALL have the states IDLE, LOAD, WAIT_BUSY and WAIT_DONE, with these transitions:
  - IDLE goes to LOAD when the FIFO is not empty and tx_busy is 0.
  - LOAD lasts one cycle. It asserts tx_start, drives tx_data_in with the FIFO head, pops the FIFO, and goes to WAIT_BUSY.
  - WAIT_BUSY goes to WAIT_DONE when tx_busy is 1.
  - WAIT_DONE goes to IDLE when tx_busy is 0.
- REQ-016: tx_data_in SHALL hold the last byte launched until the next LOAD.
- REQ-017: On rx_valid, rx_hold SHALL be loaded with rx_data and rx_full SHALL be set.
  - If rx_full was already 1 and the same cycle carries no RXDATA rd_stb, rx_overrun SHALL be set.
  - If rx_valid and an RXDATA rd_stb occur together, the read returns the old byte, the new byte is stored, rx_full stays 1, and rx_overrun is unchanged.
- REQ-018: All register updates SHALL occur on the rising edge of clk.

Reset
- REQ-019: While n_reset is 0 at a clk edge, the following SHALL be cleared:
  - FIFO pointers and count
  - rx_hold, rx_full, rx_overrun, tx_overflow
  - rd_q, wr_q
  - FSM state to IDLE
  - tx_start=0, tx_data_in=0, irq=0
- REQ-020: At the same reset, BAUD SHALL be loaded with BAUD_RESET.
- REQ-021: A reset during LOAD, WAIT_BUSY or WAIT_DONE SHALL abandon the transfer, discard all FIFO contents and not produce a further tx_start.

Configuration
- REQ-022: When macro MMIO_UART_IRQ_EN is defined:
  - Offset 0x10 IRQ_EN is read/write on bits [1:0].
  - irq is registered as (IRQ_EN[0] & rx_full) | (IRQ_EN[1] & tx_empty & state==IDLE).
  - IRQ_EN resets to 0.
- REQ-023: When MMIO_UART_IRQ_EN is undefined, irq SHALL be constant 0, and offset 0x10 SHALL read 0 and ignore writes.

Verification
- REQ-024: Write TXDATA=0x41 with tx_busy modelled 1 from the cycle after tx_start for 10 cycles -> exactly one tx_start pulse with tx_data_in=0x41 two cycles after the write edge; STATUS[1]=1 afterwards.
- REQ-025: Five TXDATA writes while tx_busy is held 1 -> the first four are accepted, the fifth sets STATUS[5]; after tx_busy is released the bytes go out in order; writing STATUS=0x20 clears bit 5.
- REQ-026: rx_valid with 0x55 then rx_valid with 0xAA and no read -> RXDATA=0xAA, STATUS[3:2]=2'b11; one RXDATA read then clears STATUS[2].
- REQ-027: memory_read held for 3 cycles on RXDATA -> exactly one pop; an access with address[31:16]=16'h0002 -> rdata=0 and no side effects.
- REQ-028: BAUD written to 0x1B1, then n_reset pulsed in WAIT_BUSY with 2 bytes queued -> baud_tick_max=433, STATUS=0x02, and no further tx_start.
- REQ-029: With MMIO_UART_IRQ_EN defined, write IRQ_EN=1 then rx_valid -> irq=1 on the next cycle and irq=0 the cycle after an RXDATA read.

Source files
------------

// File: rtl/mmio_uart_ctrl.sv
// mmio_uart_ctrl: memory-mapped control block for a byte UART.
//
// Decodes a 64 KiB region tagged by address[31:16] == BASE and exposes:
//   0x00 TXDATA  (W)   push a byte into the TX FIFO; reads return 0
//   0x04 RXDATA  (R)   received byte; a read clears rx_full
//   0x08 STATUS  (R/W1C) {tx_overflow, tx_busy, rx_overrun, rx_full, tx_empty, tx_full}
//   0x0C BAUD    (R/W) 16-bit divider, mirrored on baud_tick_max
//   0x10 IRQ_EN  (R/W) bits [1:0], only when MMIO_UART_IRQ_EN is defined
// A transmit FSM drains the FIFO into the UART, one tx_start strobe per byte.
//
// Ports:
//   clk, n_reset           clock, synchronous active-low reset
//   address, wdata, rdata  CPU bus (rdata is combinational)
//   memory_read/write      level requests; side effects on the first cycle only
//   tx_start, tx_data_in   transmit strobe and byte to the UART
//   tx_busy                UART transmitter busy
//   rx_valid, rx_data      received-byte strobe and byte
//   baud_tick_max          BAUD register
//   irq                    interrupt request (constant 0 unless MMIO_UART_IRQ_EN)
//
// Build option: define MMIO_UART_IRQ_EN to add the IRQ_EN register and irq logic.
module mmio_uart_ctrl #(
  parameter logic [15:0] BASE       = 16'h0003,
  parameter int unsigned TXF_DEPTH  = 4,
  parameter logic [15:0] BAUD_RESET = 16'd433
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        memory_read,
  input  logic        memory_write,
  output logic        tx_start,
  output logic [7:0]  tx_data_in,
  input  logic        tx_busy,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [15:0] baud_tick_max,
  output logic        irq
);

  localparam int unsigned PtrW = $clog2(TXF_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(TXF_DEPTH);

  localparam logic [15:0] OffTxData = 16'h0000;
  localparam logic [15:0] OffRxData = 16'h0004;
  localparam logic [15:0] OffStatus = 16'h0008;
  localparam logic [15:0] OffBaud   = 16'h000C;
  localparam logic [15:0] OffIrqEn  = 16'h0010;

  typedef enum logic [1:0] {StIdle, StLoad, StWaitBusy, StWaitDone} tx_state_e;

  // Bus decode and first-cycle strobes
  logic        hit;
  logic [15:0] offset;
  logic        rd_q, wr_q;
  logic        rd_stb, wr_stb;

  assign hit    = (address[31:16] == BASE);
  assign offset = address[15:0];
  assign rd_stb = memory_read & hit & ~rd_q;
  assign wr_stb = memory_write & hit & ~wr_q;

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:16];

  // State
  tx_state_e       state_q;
  logic [7:0]      fifo_mem [TXF_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [7:0]      rx_hold_q, rx_hold_d;
  logic            rx_full_q, rx_full_d;
  logic            rx_overrun_q, rx_overrun_d;
  logic            tx_overflow_q, tx_overflow_d;
  logic [15:0]     baud_q, baud_d;

  logic tx_full, tx_empty;
  logic push_req, push_ok, pop;
  logic rx_rd, status_wr;

  assign tx_full   = (count_q == DepthCnt);
  assign tx_empty  = (count_q == '0);
  assign push_req  = wr_stb && (offset == OffTxData);
  // A full FIFO still accepts a byte in the cycle the FSM pops one.
  assign pop       = (state_q == StLoad) && !tx_empty;
  assign push_ok   = push_req && (!tx_full || pop);
  assign rx_rd     = rd_stb && (offset == OffRxData);
  assign status_wr = wr_stb && (offset == OffStatus);

  assign baud_tick_max = baud_q;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    rx_hold_d     = rx_hold_q;
    rx_full_d     = rx_full_q;
    rx_overrun_d  = rx_overrun_q;
    tx_overflow_d = tx_overflow_q;
    baud_d        = baud_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (rx_rd) rx_full_d = 1'b0;
    if (status_wr && wdata[3]) rx_overrun_d  = 1'b0;
    if (status_wr && wdata[5]) tx_overflow_d = 1'b0;

    // A new byte wins over a same-cycle read; the read already returned the old byte.
    if (rx_valid) begin
      rx_hold_d = rx_data;
      rx_full_d = 1'b1;
      if (rx_full_q && !rx_rd) rx_overrun_d = 1'b1;
    end

    if (push_req && !push_ok) tx_overflow_d = 1'b1;

    if (wr_stb && (offset == OffBaud)) baud_d = wdata[15:0];
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rx_hold_q     <= 8'h00;
      rx_full_q     <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_overflow_q <= 1'b0;
      baud_q        <= BAUD_RESET;
    end else begin
      rd_q          <= memory_read;
      wr_q          <= memory_write;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      rx_hold_q     <= rx_hold_d;
      rx_full_q     <= rx_full_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_overflow_q <= tx_overflow_d;
      baud_q        <= baud_d;
    end
  end

  // Storage only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= wdata[7:0];
  end

  // Transmit FSM with registered strobe and data
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q    <= StIdle;
      tx_start   <= 1'b0;
      tx_data_in <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!tx_empty && !tx_busy) state_q <= StLoad;
        end
        StLoad: begin
          tx_start   <= 1'b1;
          tx_data_in <= fifo_mem[rd_ptr_q];
          state_q    <= StWaitBusy;
        end
        StWaitBusy: begin
          if (tx_busy) state_q <= StWaitDone;
        end
        StWaitDone: begin
          if (!tx_busy) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef MMIO_UART_IRQ_EN
  logic [1:0] irq_en_q;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      irq_en_q <= 2'b00;
      irq      <= 1'b0;
    end else begin
      if (wr_stb && (offset == OffIrqEn)) irq_en_q <= wdata[1:0];
      irq <= (irq_en_q[0] & rx_full_q) |
             (irq_en_q[1] & tx_empty & (state_q == StIdle));
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Read mux
  always_comb begin
    rdata = 32'h0;
    if (memory_read && hit) begin
      case (offset)
        OffRxData: rdata = {24'h0, rx_hold_q};
        OffStatus: rdata = {26'h0, tx_overflow_q, tx_busy, rx_overrun_q,
                            rx_full_q, tx_empty, tx_full};
        OffBaud:   rdata = {16'h0, baud_q};
`ifdef MMIO_UART_IRQ_EN
        OffIrqEn:  rdata = {30'h0, irq_en_q};
`endif
        default:   rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
module tb_mmio_uart_ctrl;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        memory_read;
  logic        memory_write;
  logic        tx_start;
  logic [7:0]  tx_data_in;
  logic        tx_busy;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [15:0] baud_tick_max;
  logic        irq;

  mmio_uart_ctrl dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .address       (address),
    .wdata         (wdata),
    .rdata         (rdata),
    .memory_read   (memory_read),
    .memory_write  (memory_write),
    .tx_start      (tx_start),
    .tx_data_in    (tx_data_in),
    .tx_busy       (tx_busy),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .baud_tick_max (baud_tick_max),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] A_TX   = 32'h0003_0000;
  localparam logic [31:0] A_RX   = 32'h0003_0004;
  localparam logic [31:0] A_STAT = 32'h0003_0008;
  localparam logic [31:0] A_BAUD = 32'h0003_000C;
  localparam logic [31:0] A_IRQ  = 32'h0003_0010;

  int n_checks = 0;
  int n_errors = 0;

  // UART transmitter model: busy for 10 cycles after each observed tx_start.
  logic       busy_hold = 1'b0;
  logic       busy_auto = 1'b1;
  int         busy_cnt  = 0;
  int         n_starts  = 0;
  logic [7:0] sent [$];

  assign tx_busy = busy_hold | (busy_cnt != 0);

  always @(posedge clk) begin
    if (tx_start) begin
      sent.push_back(tx_data_in);
      n_starts = n_starts + 1;
      if (busy_auto) busy_cnt <= 10;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mmio_write(input logic [31:0] addr, input logic [31:0] data);
    address      = addr;
    wdata        = data;
    memory_write = 1'b1;
    step();
    memory_write = 1'b0;
    step();
  endtask

  task automatic mmio_read(input logic [31:0] addr, output logic [31:0] data);
    address     = addr;
    memory_read = 1'b1;
    #1 data = rdata;
    step();
    memory_read = 1'b0;
    step();
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
  endtask

  logic [31:0] rd;
  int          starts0;
  logic        seen;

  initial begin
    n_reset      = 1'b0;
    address      = 32'h0;
    wdata        = 32'h0;
    memory_read  = 1'b0;
    memory_write = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    repeat (3) step();
    n_reset = 1'b1;
    step();

    // Reset state
    check_eq("rst_tx_start", {31'h0, tx_start}, 32'h0);
    check_eq("rst_tx_data", {24'h0, tx_data_in}, 32'h0);
    check_eq("rst_irq", {31'h0, irq}, 32'h0);
    check_eq("rst_baud", {16'h0, baud_tick_max}, 32'd433);
    mmio_read(A_STAT, rd);
    check_eq("rst_status", rd, 32'h02);

    // Single byte: tx_start two cycles after the write edge
    address = A_TX; wdata = 32'h41; memory_write = 1'b1;
    step();
    memory_write = 1'b0;
    check_eq("tx1_start_e0", {31'h0, tx_start}, 32'h0);
    step();
    check_eq("tx1_start_e1", {31'h0, tx_start}, 32'h0);
    step();
    check_eq("tx1_start_e2", {31'h0, tx_start}, 32'h1);
    check_eq("tx1_data", {24'h0, tx_data_in}, 32'h41);
    step();
    check_eq("tx1_start_e3", {31'h0, tx_start}, 32'h0);
    repeat (20) step();
    check_eq("tx1_nstarts", n_starts, 1);
    check_eq("tx1_hold", {24'h0, tx_data_in}, 32'h41);
    mmio_read(A_STAT, rd);
    check_eq("tx1_status", rd, 32'h02);
    mmio_read(A_TX, rd);
    check_eq("txdata_read0", rd, 32'h0);

    // FIFO fill and overflow while the UART is busy
    sent.delete();
    busy_hold = 1'b1;
    for (int i = 0; i < 4; i++) mmio_write(A_TX, 32'h10 + i);
    mmio_read(A_STAT, rd);
    check_eq("fifo_full_status", rd, 32'h11);
    mmio_write(A_TX, 32'h14);
    mmio_read(A_STAT, rd);
    check_eq("fifo_ovf_status", rd, 32'h31);
    busy_hold = 1'b0;
    repeat (80) step();
    check_eq("fifo_nsent", sent.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < sent.size()) check_eq("fifo_order", {24'h0, sent[i]}, 32'h10 + i);
    end
    mmio_write(A_STAT, 32'h20);
    mmio_read(A_STAT, rd);
    check_eq("ovf_w1c", rd, 32'h02);

    // RX overrun
    rx_pulse(8'h55);
    step();
    rx_pulse(8'hAA);
    step();
    mmio_read(A_STAT, rd);
    check_eq("rx_ovr_status", rd, 32'h0E);
    mmio_read(A_RX, rd);
    check_eq("rx_ovr_data", rd, 32'hAA);
    mmio_read(A_STAT, rd);
    check_eq("rx_after_read", rd, 32'h0A);
    mmio_write(A_STAT, 32'h08);
    mmio_read(A_STAT, rd);
    check_eq("ovr_w1c", rd, 32'h02);

    // Read and new byte in the same cycle
    rx_pulse(8'h11);
    step();
    address = A_RX; memory_read = 1'b1; rx_valid = 1'b1; rx_data = 8'h22;
    #1 rd = rdata;
    step();
    memory_read = 1'b0; rx_valid = 1'b0;
    step();
    check_eq("rdrx_old", rd, 32'h11);
    mmio_read(A_STAT, rd);
    check_eq("rdrx_status", rd, 32'h06);
    mmio_read(A_RX, rd);
    check_eq("rdrx_new", rd, 32'h22);

    // Held read pops once: a byte arriving mid-read must survive
    rx_pulse(8'h33);
    step();
    address = A_RX; memory_read = 1'b1;
    #1 rd = rdata;
    step();
    rx_valid = 1'b1; rx_data = 8'h44;
    step();
    rx_valid = 1'b0;
    step();
    memory_read = 1'b0;
    step();
    check_eq("held_rd_data", rd, 32'h33);
    mmio_read(A_STAT, rd);
    check_eq("held_rd_status", rd, 32'h06);
    mmio_read(A_RX, rd);
    check_eq("held_rd_next", rd, 32'h44);

    // Region miss and unmapped offsets
    rx_pulse(8'h66);
    step();
    mmio_read(32'h0002_0004, rd);
    check_eq("miss_rdata", rd, 32'h0);
    mmio_read(A_STAT, rd);
    check_eq("miss_no_pop", rd, 32'h06);
    mmio_write(32'h0002_000C, 32'hBEEF);
    check_eq("miss_no_write", {16'h0, baud_tick_max}, 32'd433);
    mmio_read(32'h0003_0014, rd);
    check_eq("unmapped", rd, 32'h0);
    mmio_read(A_RX, rd);

    // BAUD
    mmio_write(A_BAUD, 32'h1B1);
    check_eq("baud_1b1", {16'h0, baud_tick_max}, 32'h1B1);
    mmio_write(A_BAUD, 32'hFFFF_0077);
    check_eq("baud_77", {16'h0, baud_tick_max}, 32'h77);
    mmio_read(A_BAUD, rd);
    check_eq("baud_read", rd, 32'h77);

`ifndef MMIO_UART_IRQ_EN
    mmio_write(A_IRQ, 32'h3);
    mmio_read(A_IRQ, rd);
    check_eq("irqen_absent", rd, 32'h0);
    check_eq("irq_const", {31'h0, irq}, 32'h0);
`endif

    // Reset in WAIT_BUSY with two bytes queued
    busy_auto = 1'b0;
    starts0 = n_starts;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) mmio_write(A_TX, 32'hA0 + i);
    for (int i = 0; i < 20 && !seen; i++) begin
      if (n_starts != starts0) seen = 1'b1;
      else step();
    end
    check_eq("rst_mid_launch", n_starts - starts0, 1);
    n_reset = 1'b0;
    step();
    n_reset = 1'b1;
    busy_auto = 1'b1;
    check_eq("rst_mid_baud", {16'h0, baud_tick_max}, 32'd433);
    check_eq("rst_mid_txdata", {24'h0, tx_data_in}, 32'h0);
    mmio_read(A_STAT, rd);
    check_eq("rst_mid_status", rd, 32'h02);
    repeat (30) step();
    check_eq("rst_mid_nostart", n_starts - starts0, 1);

`ifdef MMIO_UART_IRQ_EN
    mmio_write(A_IRQ, 32'h1);
    mmio_read(A_IRQ, rd);
    check_eq("irqen_read", rd, 32'h1);
    rx_pulse(8'h77);
    check_eq("irq_pre", {31'h0, irq}, 32'h0);
    step();
    check_eq("irq_set", {31'h0, irq}, 32'h1);
    mmio_read(A_RX, rd);
    check_eq("irq_clr", {31'h0, irq}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
